histogram_decompressor: RTL and testbench

HISTOGRAM_DECOMPRESSOR -- requirements
Module: histogram_decompressor

---
 rtl/histogram_decompressor.sv | 136 +++++++++++++
 tb/tb_histogram_decompressor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_decompressor.sv
// Regenerates a stream of {a,b} bit-pairs from a four-bin histogram, one pair per
// valid/ready transfer, grouped in bin order 00, 01, 10, 11.
module histogram_decompressor #(
  parameter int unsigned STREAM_LENGTH = 128,
  parameter int unsigned COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] count_00,
  input  logic [COUNTER_WIDTH-1:0] count_01,
  input  logic [COUNTER_WIDTH-1:0] count_10,
  input  logic [COUNTER_WIDTH-1:0] count_11,
  input  logic                     ready_in,
  output logic                     valid_out,
  output logic                     stream_a,
  output logic                     stream_b,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned SUM_W  = COUNTER_WIDTH + 2;
  localparam int unsigned EMIT_W = $clog2(STREAM_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t                          state_q, state_d;
  logic [3:0][COUNTER_WIDTH-1:0]   rem_q, rem_d;
  logic [1:0]                      bin_q, bin_d;
  logic [EMIT_W-1:0]               emitted_q, emitted_d;
  logic                            err_d;
  logic [SUM_W-1:0]                sum;
  logic                            sum_ok;
  logic                            xfer;
  logic [1:0]                      first_bin, next_bin;
  logic                            first_hit, next_hit;

  assign sum = SUM_W'(count_00) + SUM_W'(count_01) + SUM_W'(count_10) + SUM_W'(count_11);
  assign sum_ok = (32'(sum) == STREAM_LENGTH);
  assign xfer = valid_out && ready_in;

  // Lowest nonzero bin overall, and lowest nonzero bin above the current one.
  always_comb begin
    first_bin = 2'd0;
    first_hit = 1'b0;
    next_bin  = bin_q;
    next_hit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!first_hit && rem_q[i] != '0) begin
        first_bin = 2'(i);
        first_hit = 1'b1;
      end
      if (!next_hit && i > int'(bin_q) && rem_q[i] != '0) begin
        next_bin = 2'(i);
        next_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    bin_d     = bin_q;
    emitted_d = emitted_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sum_ok) begin
            rem_d   = {count_11, count_10, count_01, count_00};
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        bin_d     = first_bin;
        emitted_d = '0;
        state_d   = EMIT;
      end
      EMIT: begin
        if (xfer) begin
          if (rem_q[bin_q] != '0) begin
            rem_d[bin_q] = rem_q[bin_q] - COUNTER_WIDTH'(1);
          end
          if (emitted_q != EMIT_W'(STREAM_LENGTH)) begin
            emitted_d = emitted_q + EMIT_W'(1);
          end
          // Bin drained: move to the next populated bin on the same edge.
          if (rem_q[bin_q] == COUNTER_WIDTH'(1)) begin
            bin_d = next_bin;
          end
          if (emitted_q == EMIT_W'(STREAM_LENGTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      bin_q     <= '0;
      emitted_q <= '0;
      valid_out <= 1'b0;
      stream_a  <= 1'b0;
      stream_b  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      bin_q     <= bin_d;
      emitted_q <= emitted_d;
      valid_out <= (state_d == EMIT);
      stream_a  <= (state_d == EMIT) && bin_d[1];
      stream_b  <= (state_d == EMIT) && bin_d[0];
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_histogram_decompressor.sv
// Scoreboard bench for histogram_decompressor with an 8-pair frame.
module tb_histogram_decompressor;

  localparam int unsigned SL = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] count_00, count_01, count_10, count_11;
  logic          ready_in;
  logic          valid_out, stream_a, stream_b, busy, done, err;

  logic [1:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  histogram_decompressor #(.STREAM_LENGTH(SL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .count_00(count_00), .count_01(count_01), .count_10(count_10), .count_11(count_11),
    .ready_in(ready_in), .valid_out(valid_out), .stream_a(stream_a), .stream_b(stream_b),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_counts(input int a, input int b, input int c, input int d);
    count_00 = CW'(a);
    count_01 = CW'(b);
    count_10 = CW'(c);
    count_11 = CW'(d);
  endtask

  task automatic push_pairs(input int a, input int b, input int c, input int d);
    repeat (a) exp_q.push_back(2'b00);
    repeat (b) exp_q.push_back(2'b01);
    repeat (c) exp_q.push_back(2'b10);
    repeat (d) exp_q.push_back(2'b11);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({valid_out, stream_a, stream_b, busy, done, err} !== 6'b0)
      $display("FAIL reset_outputs got=%b want=000000", {valid_out, stream_a, stream_b, busy, done, err});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // Runs one frame with ready_in=1 and checks pairs, latency, gaps and err.
  task automatic test_frame(input string name, input int a, input int b, input int c, input int d);
    int first_v, last_v, done_at, nxfer, err_seen;
    logic [1:0] exp;
    first_v = -1; last_v = -1; done_at = -1; nxfer = 0; err_seen = 0;
    @(negedge clk);
    set_counts(a, b, c, d);
    push_pairs(a, b, c, d);
    start = 1'b1;
    ready_in = 1'b1;
    for (int cy = 1; cy <= 16; cy++) begin
      @(negedge clk);
      start = 1'b0;
      set_counts(15, 15, 0, 0);
      if (err) err_seen++;
      if (done && done_at < 0) done_at = cy;
      if (valid_out) begin
        if (first_v < 0) first_v = cy;
        last_v = cy;
        nxfer++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        chk_cnt++;
        if ({stream_a, stream_b} !== exp)
          $display("FAIL %s_pair cycle=%0d got=%b want=%b", name, cy, {stream_a, stream_b}, exp);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (first_v != 2 || last_v != 9 || nxfer != 8)
      $display("FAIL %s_timing first=%0d last=%0d xfers=%0d want 2/9/8", name, first_v, last_v, nxfer);
    else pass_cnt++;
    chk_cnt++;
    if (done_at != 10) $display("FAIL %s_done cycle got=%0d want=10", name, done_at);
    else pass_cnt++;
    chk_cnt++;
    if (err_seen != 0) $display("FAIL %s_err pulses got=%0d want=0", name, err_seen);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_leftover got=%0d want=0", name, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_bad_sum();
    int err_cnt, busy_seen, valid_seen;
    err_cnt = 0; busy_seen = 0; valid_seen = 0;
    @(negedge clk);
    set_counts(2, 2, 2, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL bad_sum_err got=%b want=1", err);
    else pass_cnt++;
    for (int cy = 2; cy <= 8; cy++) begin
      @(negedge clk);
      if (err) err_cnt++;
      if (busy) busy_seen++;
      if (valid_out) valid_seen++;
    end
    chk_cnt++;
    if (err_cnt != 0) $display("FAIL bad_sum_err_width extra cycles got=%0d want=0", err_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (busy_seen != 0 || valid_seen != 0)
      $display("FAIL bad_sum_idle busy=%0d valid=%0d want 0/0", busy_seen, valid_seen);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int nxfer, last_x, done_at;
    logic [1:0] exp;
    nxfer = 0; last_x = -1; done_at = -1;
    @(negedge clk);
    set_counts(2, 2, 2, 2);
    push_pairs(2, 2, 2, 2);
    start = 1'b1;
    ready_in = 1'b1;
    for (int cy = 1; cy <= 40; cy++) begin
      @(negedge clk);
      start = 1'b0;
      ready_in = ((cy % 4) == 0) || ((cy % 4) == 3) || (cy == 1);
      if (done && done_at < 0) done_at = cy;
      if (valid_out) begin
        exp = (exp_q.size() != 0) ? exp_q[0] : 2'bxx;
        chk_cnt++;
        if ({stream_a, stream_b} !== exp)
          $display("FAIL bp_pair cycle=%0d ready=%b got=%b want=%b", cy, ready_in, {stream_a, stream_b}, exp);
        else pass_cnt++;
        if (ready_in) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          nxfer++;
          last_x = cy;
        end
      end else if (exp_q.size() != 0 && cy >= 2 && done_at < 0) begin
        chk_cnt++;
        $display("FAIL bp_valid_drop cycle=%0d got=0 want=1", cy);
      end
    end
    chk_cnt++;
    if (nxfer != 8) $display("FAIL bp_xfers got=%0d want=8", nxfer);
    else pass_cnt++;
    chk_cnt++;
    if (done_at != last_x + 1 || done_at < 0)
      $display("FAIL bp_done cycle got=%0d want=%0d", done_at, last_x + 1);
    else pass_cnt++;
    ready_in = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int nxfer;
    logic [1:0] exp;
    nxfer = 0;
    @(negedge clk);
    set_counts(2, 2, 2, 2);
    push_pairs(2, 2, 2, 2);
    start = 1'b1;
    ready_in = 1'b1;
    for (int cy = 1; cy <= 20 && nxfer < 3; cy++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid_out) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        nxfer++;
        chk_cnt++;
        if ({stream_a, stream_b} !== exp)
          $display("FAIL rst_pre_pair n=%0d got=%b want=%b", nxfer, {stream_a, stream_b}, exp);
        else pass_cnt++;
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({valid_out, stream_a, stream_b, busy, done, err} !== 6'b0)
      $display("FAIL rst_async got=%b want=000000", {valid_out, stream_a, stream_b, busy, done, err});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({valid_out, busy, done} !== 3'b0)
      $display("FAIL rst_held got=%b want=000", {valid_out, busy, done});
    else pass_cnt++;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_start_held();
    int nxfer, done_cnt, done2, first2, gap_v, gap_b;
    logic [1:0] exp;
    nxfer = 0; done_cnt = 0; done2 = -1; first2 = -1; gap_v = -1; gap_b = -1;
    @(negedge clk);
    set_counts(1, 2, 3, 2);
    push_pairs(1, 2, 3, 2);
    push_pairs(0, 0, 8, 0);
    start = 1'b1;
    ready_in = 1'b1;
    for (int cy = 1; cy <= 26; cy++) begin
      @(negedge clk);
      start = (cy < 12);
      if (cy == 3) set_counts(0, 0, 8, 0);
      if (cy == 11) begin gap_v = valid_out; gap_b = busy; end
      if (done) begin done_cnt++; if (cy > 11) done2 = cy; end
      if (valid_out) begin
        if (cy > 11 && first2 < 0) first2 = cy;
        nxfer++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        chk_cnt++;
        if ({stream_a, stream_b} !== exp)
          $display("FAIL held_pair cycle=%0d got=%b want=%b", cy, {stream_a, stream_b}, exp);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (gap_v != 0 || gap_b != 0) $display("FAIL held_idle_gap valid=%0d busy=%0d want 0/0", gap_v, gap_b);
    else pass_cnt++;
    chk_cnt++;
    if (first2 != 13 || done2 != 21 || done_cnt != 2 || nxfer != 16)
      $display("FAIL held_second_frame first=%0d done=%0d dones=%0d xfers=%0d want 13/21/2/16",
               first2, done2, done_cnt, nxfer);
    else pass_cnt++;
    start = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ready_in = 1'b0;
    set_counts(0, 0, 0, 0);
    test_reset();
    test_frame("basic", 3, 0, 4, 1);
    test_frame("single_bin", 0, 0, 0, 8);
    test_bad_sum();
    test_backpressure();
    test_reset_mid_frame();
    test_frame("after_rst", 8, 0, 0, 0);
    test_start_held();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
